// File: rtl/ma_bundle_pkg.sv
// Field layout of the MA request bundle and the WB feedback bundle.
// Packed structs mirror the bit offsets so either view can be used.
package ma_bundle_pkg;

  localparam int unsigned MA_W     = 79;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned VAL_LSB  = 8;
  localparam int unsigned VAL_W    = 64;
  localparam int unsigned REG_LSB  = 72;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned LOAD_BIT = 76;
  localparam int unsigned MEMW_BIT = 77;
  localparam int unsigned WR_BIT   = 78;

  localparam int unsigned WB_W       = 69;
  localparam int unsigned WB_VAL_LSB = 0;
  localparam int unsigned WB_REG_LSB = 64;
  localparam int unsigned WB_WR_BIT  = 68;

  typedef struct packed {
    logic              is_write;      // [78]
    logic              is_mem_write;  // [77]
    logic              is_load;       // [76]
    logic [REG_W-1:0]  rd;            // [75:72]
    logic [VAL_W-1:0]  value;         // [71:8]
    logic [ADDR_W-1:0] addr;          // [7:0]
  } ma_bundle_t;

  typedef struct packed {
    logic             is_write;  // [68]
    logic [REG_W-1:0] rd;        // [67:64]
    logic [VAL_W-1:0] value;     // [63:0]
  } wb_bundle_t;

  localparam ma_bundle_t MA_BUBBLE = '0;
  localparam logic       MA_BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/ex_ma_register_if.sv
// EX->MA pipeline register signal bundle; master drives EX side, slave is the register.
interface ex_ma_register_if #(
    parameter int unsigned CNT_W = 16
);
    import ma_bundle_pkg::*;

    logic                ex_valid;
    logic [VAL_W-1:0]    ex_alu_result;
    logic [VAL_W-1:0]    ex_store_data;
    logic [REG_W-1:0]    ex_store_src;
    logic [REG_W-1:0]    ex_dest;
    logic                ex_is_load;
    logic                ex_is_mem_write;
    logic                ex_is_write;
    logic [REG_W-1:0]    id_src_a;
    logic [REG_W-1:0]    id_src_b;
    logic                stall;
    logic                flush;
    logic [WB_W-1:0]     wb_bundle;
    logic [MA_W-1:0]     ma_bundle;
    logic                ma_valid;
    logic                load_use_hazard;
    logic                err_illegal;
    logic [CNT_W-1:0]    issued_count;

    modport master (
        output ex_valid, ex_alu_result, ex_store_data, ex_store_src, ex_dest,
               ex_is_load, ex_is_mem_write, ex_is_write, id_src_a, id_src_b,
               stall, flush, wb_bundle,
        input  ma_bundle, ma_valid, load_use_hazard, err_illegal, issued_count
    );

    modport slave (
        input  ex_valid, ex_alu_result, ex_store_data, ex_store_src, ex_dest,
               ex_is_load, ex_is_mem_write, ex_is_write, id_src_a, id_src_b,
               stall, flush, wb_bundle,
        output ma_bundle, ma_valid, load_use_hazard, err_illegal, issued_count
    );

endinterface

// File: rtl/store_data_fwd.sv
// Three-way priority forwarding mux: MA-stage write, then WB-stage write, then register file.
module store_data_fwd #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned REG_W  = 4
) (
    input  logic [REG_W-1:0]  src,
    input  logic              ma_hit,
    input  logic [REG_W-1:0]  ma_reg,
    input  logic [DATA_W-1:0] ma_data,
    input  logic              wb_hit,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_data,
    output logic [DATA_W-1:0] data
);

    always_comb begin
        data = rf_data;
        if (ma_hit && (ma_reg == src)) begin
            data = ma_data;
        end else if (wb_hit && (wb_reg == src)) begin
            data = wb_data;
        end
    end

endmodule

// File: rtl/ex_ma_register.sv
// EX->MA pipeline register: bundle packing, store forwarding, stall/flush,
// load-use hazard detection, illegal-op flag and issued-instruction counter.
module ex_ma_register
    import ma_bundle_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    ex_ma_register_if.slave  bus
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    ma_bundle_t       ma_q, ma_d;
    logic             valid_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;
    wb_bundle_t       wb;
    logic             illegal;
    logic             take;
    logic [VAL_W-1:0] fwd_data;

    assign wb      = bus.wb_bundle;
    assign illegal = bus.ex_is_load & bus.ex_is_mem_write;
    assign take    = bus.ex_valid & ~illegal;

    // Loads never forward from MA: their value field is an address result, not the loaded data.
    store_data_fwd #(
        .DATA_W (VAL_W),
        .REG_W  (REG_W)
    ) u_store_data_fwd (
        .src     (bus.ex_store_src),
        .ma_hit  (valid_q & ma_q.is_write & ~ma_q.is_load),
        .ma_reg  (ma_q.rd),
        .ma_data (ma_q.value),
        .wb_hit  (wb.is_write),
        .wb_reg  (wb.rd),
        .wb_data (wb.value),
        .rf_data (bus.ex_store_data),
        .data    (fwd_data)
    );

    always_comb begin
        ma_d = MA_BUBBLE;
        if (take) begin
            ma_d.addr         = bus.ex_alu_result[ADDR_W-1:0];
            ma_d.value        = bus.ex_is_mem_write ? fwd_data : bus.ex_alu_result;
            ma_d.rd           = bus.ex_dest;
            ma_d.is_load      = bus.ex_is_load;
            ma_d.is_mem_write = bus.ex_is_mem_write;
            ma_d.is_write     = bus.ex_is_write;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ma_q    <= MA_BUBBLE;
            valid_q <= MA_BUBBLE_VALID;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else if (bus.flush) begin
            ma_q    <= MA_BUBBLE;
            valid_q <= MA_BUBBLE_VALID;
        end else if (!bus.stall) begin
            ma_q    <= ma_d;
            valid_q <= take;
            if (take) begin
                cnt_q <= cnt_q + CntOne;
            end
            if (bus.ex_valid && illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.ma_bundle       = ma_q;
    assign bus.ma_valid        = valid_q;
    assign bus.err_illegal     = err_q;
    assign bus.issued_count    = cnt_q;
    assign bus.load_use_hazard = valid_q & ma_q.is_load & ma_q.is_write &
                                 ((ma_q.rd == bus.id_src_a) | (ma_q.rd == bus.id_src_b));

endmodule
